// File: rtl/ddr3_app_pkg.sv
// Shared constants and types for the DDR3 application-port arbiter.
package ddr3_app_pkg;

    // Gowin DDR3 controller app_cmd encodings
    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;

    // Default widths of the controller application interface
    localparam int unsigned ADDR_W_DEF    = 28;
    localparam int unsigned DATA_W_DEF    = 128;
    localparam int unsigned BURST_W_DEF   = 6;
    localparam int unsigned TAG_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCmd   = 2'd1,
        StWdata = 2'd2
    } arb_state_e;

endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO of 1-bit requester tags, one entry per outstanding read command.
module tag_fifo #(
    parameter int unsigned Depth = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so push on a full FIFO is fine when popping.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PtrW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PtrW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointer registers, flushed by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ddr3_app_arbiter.sv
// Two-port round-robin arbiter in front of the Gowin DDR3 controller app interface.
// Commands and write bursts are serialised; read returns are routed by an in-order tag FIFO.
module ddr3_app_arbiter
    import ddr3_app_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BURST_W   = BURST_W_DEF,
    parameter int unsigned TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_calib_complete,
    input  logic [1:0]            req_cmd_valid,
    output logic [1:0]            req_cmd_ready,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*BURST_W-1:0]  req_burst,
    input  logic [1:0]            req_wdata_valid,
    output logic [1:0]            req_wdata_ready,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_rdata_valid,
    output logic [1:0]            req_rdata_end,
    output logic [DATA_W-1:0]     req_rdata,
    output logic                  app_cmd_en,
    output logic [2:0]            app_cmd,
    output logic [ADDR_W-1:0]     app_addr,
    output logic [BURST_W-1:0]    app_burst_number,
    input  logic                  app_cmd_rdy,
    output logic                  app_wdata_en,
    output logic                  app_wdata_end,
    output logic [DATA_W-1:0]     app_wdata,
    input  logic                  app_wdata_rdy,
    input  logic                  app_rdata_valid,
    input  logic                  app_rdata_end,
    input  logic [DATA_W-1:0]     app_rdata,
    output logic                  rd_orphan
);

    arb_state_e         state_q, state_d;
    logic               gnt_q, gnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] beat_q, beat_d;
    logic               prio_q, prio_d;
    logic               orphan_q, orphan_d;

    logic [1:0] eligible;
    logic       pick;
    logic       pick_ok;
    logic       wdata_fire;
    logic       last_beat;
    logic       fifo_push, fifo_pop, fifo_head, fifo_full, fifo_empty;

    tag_fifo #(
        .Depth (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .din_i   (gnt_q),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Round-robin pick: prio_q names the favoured requester; reads wait while the tag FIFO is full.
    always_comb begin
        eligible = req_cmd_valid & (req_we | {2{~fifo_full}});
        pick     = prio_q;
        pick_ok  = 1'b0;
        if (eligible[prio_q]) begin
            pick    = prio_q;
            pick_ok = 1'b1;
        end else if (eligible[~prio_q]) begin
            pick    = ~prio_q;
            pick_ok = 1'b1;
        end
    end

    assign last_beat = (beat_q == burst_q);
    assign fifo_pop  = app_rdata_valid & app_rdata_end & ~fifo_empty;

    // FSM next-state, command latch, beat counter and priority update
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        prio_d    = prio_q;
        fifo_push = 1'b0;
        orphan_d  = orphan_q | (app_rdata_valid & fifo_empty);
        unique case (state_q)
            StIdle: begin
                if (init_calib_complete && pick_ok) begin
                    gnt_d   = pick;
                    we_d    = req_we[pick];
                    addr_d  = pick ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                    burst_d = pick ? req_burst[2*BURST_W-1:BURST_W] : req_burst[BURST_W-1:0];
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (app_cmd_rdy) begin
                    if (we_q) begin
                        beat_d  = '0;
                        state_d = StWdata;
                    end else begin
                        fifo_push = 1'b1;
                        prio_d    = ~gnt_q;
                        state_d   = StIdle;
                    end
                end
            end
            StWdata: begin
                if (wdata_fire) begin
                    if (last_beat) begin
                        prio_d  = ~gnt_q;
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + BURST_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and latch registers; reset also returns priority to requester 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            prio_q   <= 1'b0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            prio_q   <= prio_d;
            orphan_q <= orphan_d;
        end
    end

    // Output decode from registered state and latch; read routing is combinational
    always_comb begin
        req_cmd_ready    = '0;
        req_wdata_ready  = '0;
        req_rdata_valid  = '0;
        req_rdata_end    = '0;
        app_cmd_en       = 1'b0;
        app_cmd          = '0;
        app_addr         = '0;
        app_burst_number = '0;
        app_wdata_en     = 1'b0;
        app_wdata_end    = 1'b0;
        app_wdata        = '0;
        wdata_fire       = 1'b0;

        if (state_q == StCmd) begin
            app_cmd_en           = 1'b1;
            app_cmd              = we_q ? APP_CMD_WR : APP_CMD_RD;
            app_addr             = addr_q;
            app_burst_number     = burst_q;
            req_cmd_ready[gnt_q] = app_cmd_rdy;
        end

        if (state_q == StWdata) begin
            app_wdata              = gnt_q ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            wdata_fire             = req_wdata_valid[gnt_q] & app_wdata_rdy;
            app_wdata_en           = wdata_fire;
            app_wdata_end          = wdata_fire & last_beat;
            req_wdata_ready[gnt_q] = app_wdata_rdy;
        end

        // With no outstanding tag the beat has no owner and is dropped
        if (!fifo_empty) begin
            req_rdata_valid[fifo_head] = app_rdata_valid;
            req_rdata_end[fifo_head]   = app_rdata_end;
        end
    end

    assign req_rdata = app_rdata;
    assign rd_orphan = orphan_q;

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Directed self-checking bench for ddr3_app_arbiter.
module tb_ddr3_app_arbiter;

    localparam int unsigned ADDR_W  = 28;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned BURST_W = 6;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  init_calib_complete;
    logic [1:0]            req_cmd_valid;
    logic [1:0]            req_cmd_ready;
    logic [1:0]            req_we;
    logic [2*ADDR_W-1:0]   req_addr;
    logic [2*BURST_W-1:0]  req_burst;
    logic [1:0]            req_wdata_valid;
    logic [1:0]            req_wdata_ready;
    logic [2*DATA_W-1:0]   req_wdata;
    logic [1:0]            req_rdata_valid;
    logic [1:0]            req_rdata_end;
    logic [DATA_W-1:0]     req_rdata;
    logic                  app_cmd_en;
    logic [2:0]            app_cmd;
    logic [ADDR_W-1:0]     app_addr;
    logic [BURST_W-1:0]    app_burst_number;
    logic                  app_cmd_rdy;
    logic                  app_wdata_en;
    logic                  app_wdata_end;
    logic [DATA_W-1:0]     app_wdata;
    logic                  app_wdata_rdy;
    logic                  app_rdata_valid;
    logic                  app_rdata_end;
    logic [DATA_W-1:0]     app_rdata;
    logic                  rd_orphan;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ddr3_app_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_W   (BURST_W),
        .TAG_DEPTH (8)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .init_calib_complete (init_calib_complete),
        .req_cmd_valid       (req_cmd_valid),
        .req_cmd_ready       (req_cmd_ready),
        .req_we              (req_we),
        .req_addr            (req_addr),
        .req_burst           (req_burst),
        .req_wdata_valid     (req_wdata_valid),
        .req_wdata_ready     (req_wdata_ready),
        .req_wdata           (req_wdata),
        .req_rdata_valid     (req_rdata_valid),
        .req_rdata_end       (req_rdata_end),
        .req_rdata           (req_rdata),
        .app_cmd_en          (app_cmd_en),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_burst_number    (app_burst_number),
        .app_cmd_rdy         (app_cmd_rdy),
        .app_wdata_en        (app_wdata_en),
        .app_wdata_end       (app_wdata_end),
        .app_wdata           (app_wdata),
        .app_wdata_rdy       (app_wdata_rdy),
        .app_rdata_valid     (app_rdata_valid),
        .app_rdata_end       (app_rdata_end),
        .app_rdata           (app_rdata),
        .rd_orphan           (rd_orphan)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] beat_data(input int unsigned tag, input int unsigned b);
        return {4{32'hC0DE_0000 + 32'(tag * 256 + b)}};
    endfunction

    task automatic do_reset();
        rst                 = 1'b1;
        init_calib_complete = 1'b1;
        req_cmd_valid       = '0;
        req_we              = '0;
        req_addr            = '0;
        req_burst           = '0;
        req_wdata_valid     = '0;
        req_wdata           = '0;
        app_cmd_rdy         = 1'b1;
        app_wdata_rdy       = 1'b1;
        app_rdata_valid     = 1'b0;
        app_rdata_end       = 1'b0;
        app_rdata           = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if ({app_cmd_en, app_cmd, app_addr, app_burst_number, app_wdata_en, app_wdata_end,
             app_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_app: app_* outputs = %h, required 0",
                     {app_cmd_en, app_cmd, app_addr, app_burst_number, app_wdata_en});
        end
        n_tests++;
        if ({req_cmd_ready, req_wdata_ready, req_rdata_valid, req_rdata_end, rd_orphan}
            !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_req: req_*/rd_orphan = %b, required 0",
                     {req_cmd_ready, req_wdata_ready, req_rdata_valid, req_rdata_end, rd_orphan});
        end
    endtask

    task automatic test_single_write();
        do_reset();
        req_cmd_valid            = 2'b01;
        req_we                   = 2'b01;
        req_addr[ADDR_W-1:0]     = 28'h0123456;
        req_burst[BURST_W-1:0]   = 6'd3;
        cyc();
        n_tests++;
        if ({app_cmd_en, app_cmd, app_addr, app_burst_number, req_cmd_ready} !==
            {1'b1, 3'b000, 28'h0123456, 6'd3, 2'b01}) begin
            n_fail++;
            $display("FAIL wr_cmd: en=%b cmd=%b addr=%h burst=%0d rdy=%b, required 1 000 0123456 3 01",
                     app_cmd_en, app_cmd, app_addr, app_burst_number, req_cmd_ready);
        end
        cyc();
        req_cmd_valid = 2'b00;
        for (int b = 0; b < 4; b++) begin
            req_wdata[DATA_W-1:0] = beat_data(0, b);
            req_wdata_valid       = 2'b01;
            #1;
            n_tests++;
            if ({app_wdata_en, app_wdata_end, app_wdata, app_cmd_en, req_cmd_ready,
                 req_wdata_ready} !== {1'b1, (b == 3), beat_data(0, b), 1'b0, 2'b00, 2'b01}) begin
                n_fail++;
                $display("FAIL wr_beat%0d: en=%b end=%b data=%h cmd_en=%b rdy=%b, required 1 %b %h 0 00",
                         b, app_wdata_en, app_wdata_end, app_wdata, app_cmd_en, req_cmd_ready,
                         (b == 3), beat_data(0, b));
            end
            cyc();
        end
        n_tests++;
        if ({app_wdata_en, app_cmd_en, req_wdata_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL wr_done: wdata_en=%b cmd_en=%b wready=%b, required 0 0 00",
                     app_wdata_en, app_cmd_en, req_wdata_ready);
        end
        req_wdata_valid = 2'b00;
    endtask

    task automatic test_round_robin();
        logic [1:0]        exp_rdy;
        logic [ADDR_W-1:0] exp_addr;
        do_reset();
        req_cmd_valid            = 2'b11;
        req_we                   = 2'b00;
        req_addr                 = {28'h0BBBBBB, 28'h0AAAAAA};
        req_burst                = '0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            exp_rdy  = (k % 2 == 1) ? 2'b10 : 2'b01;
            exp_addr = (k % 2 == 1) ? 28'h0BBBBBB : 28'h0AAAAAA;
            n_tests++;
            if ({app_cmd_en, app_cmd, req_cmd_ready, app_addr} !==
                {1'b1, 3'b001, exp_rdy, exp_addr}) begin
                n_fail++;
                $display("FAIL rr_grant%0d: en=%b cmd=%b rdy=%b addr=%h, required 1 001 %b %h",
                         k, app_cmd_en, app_cmd, req_cmd_ready, app_addr, exp_rdy, exp_addr);
            end
            if (k == 3) req_cmd_valid = 2'b00;
            cyc();
        end
        // Returns arrive in issue order: tags 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            app_rdata_valid = 1'b1;
            app_rdata_end   = 1'b1;
            app_rdata       = beat_data(9, k);
            exp_rdy         = (k % 2 == 1) ? 2'b10 : 2'b01;
            #1;
            n_tests++;
            if ({req_rdata_valid, req_rdata_end, req_rdata} !== {exp_rdy, exp_rdy, beat_data(9, k)})
            begin
                n_fail++;
                $display("FAIL rr_return%0d: valid=%b end=%b data=%h, required %b %b %h",
                         k, req_rdata_valid, req_rdata_end, req_rdata, exp_rdy, exp_rdy,
                         beat_data(9, k));
            end
            cyc();
        end
        app_rdata_valid = 1'b0;
        app_rdata_end   = 1'b0;
        app_rdata       = '0;
        #1;
        n_tests++;
        if (rd_orphan !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_no_orphan: rd_orphan=%b, required 0", rd_orphan);
        end
    endtask

    task automatic test_fifo_full();
        int pulses;
        do_reset();
        pulses                   = 0;
        req_cmd_valid            = 2'b10;
        req_we                   = 2'b00;
        req_addr                 = {28'h0000100, 28'h0000000};
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (req_cmd_ready[1]) pulses++;
        end
        n_tests++;
        if (pulses != 8) begin
            n_fail++;
            $display("FAIL full_reads: accepted=%0d, required 8", pulses);
        end
        // Write from req0 still gets through while req1's read is held
        req_cmd_valid            = 2'b11;
        req_we                   = 2'b01;
        req_burst                = '0;
        req_wdata[DATA_W-1:0]    = beat_data(0, 42);
        req_wdata_valid          = 2'b01;
        cyc();
        n_tests++;
        if ({app_cmd_en, app_cmd, req_cmd_ready} !== {1'b1, 3'b000, 2'b01}) begin
            n_fail++;
            $display("FAIL full_wr_cmd: en=%b cmd=%b rdy=%b, required 1 000 01",
                     app_cmd_en, app_cmd, req_cmd_ready);
        end
        cyc();
        req_cmd_valid = 2'b10;
        #1;
        n_tests++;
        if ({app_wdata_en, app_wdata_end, app_wdata} !== {1'b1, 1'b1, beat_data(0, 42)}) begin
            n_fail++;
            $display("FAIL full_wr_beat: en=%b end=%b data=%h, required 1 1 %h",
                     app_wdata_en, app_wdata_end, app_wdata, beat_data(0, 42));
        end
        cyc();
        req_wdata_valid = 2'b00;
        for (int c = 0; c < 4; c++) begin
            cyc();
            n_tests++;
            if ({app_cmd_en, req_cmd_ready} !== 3'b000) begin
                n_fail++;
                $display("FAIL full_held%0d: cmd_en=%b rdy=%b, required 0 00",
                         c, app_cmd_en, req_cmd_ready);
            end
        end
        app_rdata_valid = 1'b1;
        app_rdata_end   = 1'b1;
        #1;
        n_tests++;
        if (req_rdata_valid !== 2'b10) begin
            n_fail++;
            $display("FAIL full_return: rvalid=%b, required 10", req_rdata_valid);
        end
        cyc();
        app_rdata_valid = 1'b0;
        app_rdata_end   = 1'b0;
        cyc();
        n_tests++;
        if ({app_cmd_en, app_cmd, req_cmd_ready} !== {1'b1, 3'b001, 2'b10}) begin
            n_fail++;
            $display("FAIL full_release: en=%b cmd=%b rdy=%b, required 1 001 10",
                     app_cmd_en, app_cmd, req_cmd_ready);
        end
        req_cmd_valid = 2'b00;
        cyc();
    endtask

    task automatic test_cmd_stall();
        do_reset();
        app_cmd_rdy              = 1'b0;
        req_cmd_valid            = 2'b01;
        req_we                   = 2'b00;
        req_addr[ADDR_W-1:0]     = 28'h0FEDCBA;
        cyc();
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if ({app_cmd_en, app_addr, req_cmd_ready} !== {1'b1, 28'h0FEDCBA, 2'b00}) begin
                n_fail++;
                $display("FAIL stall%0d: en=%b addr=%h rdy=%b, required 1 0fedcba 00",
                         c, app_cmd_en, app_addr, req_cmd_ready);
            end
            cyc();
        end
        app_cmd_rdy = 1'b1;
        #1;
        n_tests++;
        if ({app_cmd_en, app_addr, req_cmd_ready} !== {1'b1, 28'h0FEDCBA, 2'b01}) begin
            n_fail++;
            $display("FAIL stall_accept: en=%b addr=%h rdy=%b, required 1 0fedcba 01",
                     app_cmd_en, app_addr, req_cmd_ready);
        end
        cyc();
        req_cmd_valid = 2'b00;
        #1;
        n_tests++;
        if ({app_cmd_en, req_cmd_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL stall_after: en=%b rdy=%b, required 0 00", app_cmd_en, req_cmd_ready);
        end
    endtask

    task automatic test_write_gaps();
        int  b;
        logic v, r;
        do_reset();
        b                              = 0;
        req_cmd_valid                  = 2'b10;
        req_we                         = 2'b10;
        req_burst[2*BURST_W-1:BURST_W] = 6'd7;
        cyc();
        cyc();
        req_cmd_valid = 2'b00;
        for (int c = 0; c < 40 && b < 8; c++) begin
            v = (c % 3 != 2);
            r = (c % 2 == 0) || (c > 10);
            req_wdata_valid              = {v, 1'b0};
            app_wdata_rdy                = r;
            req_wdata[2*DATA_W-1:DATA_W] = beat_data(1, b);
            #1;
            n_tests++;
            if ({app_wdata_en, app_wdata_end, req_wdata_ready} !==
                {v & r, (v & r) && (b == 7), r, 1'b0}) begin
                n_fail++;
                $display("FAIL gap_c%0d: en=%b end=%b wready=%b, required %b %b %b0",
                         c, app_wdata_en, app_wdata_end, req_wdata_ready, v & r,
                         (v & r) && (b == 7), r);
            end
            if (v && r) begin
                n_tests++;
                if (app_wdata !== beat_data(1, b)) begin
                    n_fail++;
                    $display("FAIL gap_data%0d: data=%h, required %h", b, app_wdata,
                             beat_data(1, b));
                end
                b++;
            end
            cyc();
        end
        n_tests++;
        if (b != 8) begin
            n_fail++;
            $display("FAIL gap_count: beats=%0d, required 8", b);
        end
        req_wdata_valid = 2'b10;
        app_wdata_rdy   = 1'b1;
        #1;
        n_tests++;
        if ({app_wdata_en, req_wdata_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL gap_done: en=%b wready=%b, required 0 00", app_wdata_en,
                     req_wdata_ready);
        end
        req_wdata_valid = 2'b00;
    endtask

    task automatic test_orphan_and_reset();
        do_reset();
        app_rdata_valid = 1'b1;
        app_rdata_end   = 1'b1;
        app_rdata       = beat_data(7, 7);
        #1;
        n_tests++;
        if ({req_rdata_valid, req_rdata_end} !== 4'b0000) begin
            n_fail++;
            $display("FAIL orphan_route: valid=%b end=%b, required 00 00",
                     req_rdata_valid, req_rdata_end);
        end
        cyc();
        app_rdata_valid = 1'b0;
        app_rdata_end   = 1'b0;
        app_rdata       = '0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            n_tests++;
            if (rd_orphan !== 1'b1) begin
                n_fail++;
                $display("FAIL orphan_sticky%0d: rd_orphan=%b, required 1", c, rd_orphan);
            end
        end
        // Start a write burst and reset in the middle of it
        req_cmd_valid            = 2'b01;
        req_we                   = 2'b01;
        req_addr[ADDR_W-1:0]     = 28'h0055555;
        req_burst[BURST_W-1:0]   = 6'd3;
        cyc();
        cyc();
        req_cmd_valid         = 2'b00;
        req_wdata_valid       = 2'b01;
        req_wdata[DATA_W-1:0] = beat_data(0, 0);
        #1;
        n_tests++;
        if (app_wdata_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: wdata_en=%b, required 1", app_wdata_en);
        end
        rst = 1'b1;
        cyc();
        n_tests++;
        if ({app_cmd_en, app_cmd, app_addr, app_burst_number, app_wdata_en, app_wdata_end,
             app_wdata, req_cmd_ready, req_wdata_ready, req_rdata_valid, req_rdata_end,
             req_rdata, rd_orphan} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: cmd_en=%b wdata_en=%b wend=%b wready=%b orphan=%b data=%h, required all 0",
                     app_cmd_en, app_wdata_en, app_wdata_end, req_wdata_ready, rd_orphan,
                     app_wdata);
        end
        rst             = 1'b0;
        req_wdata_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_fifo_full();
        test_cmd_stall();
        test_write_gaps();
        test_orphan_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_app_arbiter.md
# ddr3_app_arbiter

Two-port round-robin arbiter that shares the Gowin DDR3 controller application interface (cmd / wr_data / rd_data channels, 128-bit, clocked by the controller's `clk_out`) between two requesters, e.g. a CPU cache port and a DMA/video port. It serialises commands and write bursts and routes in-order read returns back to the issuing requester through a tag FIFO. It sits between the requesters and `DDR3_Memory_Interface_Top` in the DDR3 top level.

## Interface
- `ADDR_W`, 28, app address width
- `DATA_W`, 128, app data beat width
- `BURST_W`, 6, width of `app_burst_number` (beats − 1)
- `TAG_DEPTH`, 8, max outstanding read commands (power of 2)

Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: controller user clock (`clk_out`)
- `rst` in 1: synchronous, active-high reset
- `init_calib_complete` in 1: controller ready
- `req_cmd_valid` in 2: per-requester command request
- `req_cmd_ready` out 2: command accepted (one-cycle pulse)
- `req_we` in 2: 1 = write, 0 = read
- `req_addr` in 2·ADDR_W: requester i at `[i*ADDR_W +: ADDR_W]`
- `req_burst` in 2·BURST_W: beats − 1
- `req_wdata_valid` in 2, `req_wdata_ready` out 2, `req_wdata` in 2·DATA_W: write beats
- `req_rdata_valid` out 2, `req_rdata_end` out 2, `req_rdata` out DATA_W (shared bus)
- `app_cmd_en` out 1, `app_cmd` out 3, `app_addr` out ADDR_W, `app_burst_number` out BURST_W, `app_cmd_rdy` in 1
- `app_wdata_en` out 1, `app_wdata_end` out 1, `app_wdata` out DATA_W, `app_wdata_rdy` in 1
- `app_rdata_valid` in 1, `app_rdata_end` in 1, `app_rdata` in DATA_W
- `rd_orphan` out 1: sticky error, read data with empty tag FIFO

## Operation
- FSM states: IDLE, CMD, WDATA.
- IDLE: grant only when `init_calib_complete`=1 and an eligible request exists. A read is eligible only if the tag FIFO is not full; a write is always eligible. Round-robin: the requester granted last has lower priority. After reset requester 0 has priority. Latch grant, we, addr, burst → CMD.
- CMD: `app_cmd_en`=1, `app_cmd`=3'b000 for write, 3'b001 for read; addr and burst come from the latch. Accept when `app_cmd_rdy`=1: pulse `req_cmd_ready[g]`. A read pushes tag g into the FIFO → IDLE. A write → WDATA with beat counter = 0.
- WDATA: `app_wdata`=`req_wdata[g]`, `app_wdata_en`=`req_wdata_valid[g] & app_wdata_rdy`, `req_wdata_ready[g]`=`app_wdata_rdy`. The counter increments per transferred beat. `app_wdata_end`=`app_wdata_en` & (counter == latched burst). On the end beat → IDLE and update priority.
- Read return: tag = FIFO head. `req_rdata_valid[tag]`=`app_rdata_valid`, and the other bit is 0. `req_rdata_end[tag]`=`app_rdata_end`. `req_rdata`=`app_rdata` broadcast. Pop on `app_rdata_valid & app_rdata_end`.
- Push and pop in the same cycle: both occur and the count is unchanged. Push and pop on a full FIFO is legal.
- `app_rdata_valid` with the FIFO empty: the beat is dropped and `rd_orphan` is set until `rst`.
- `init_calib_complete` falling: no new grants. A transaction in CMD/WDATA completes.
- `rst` mid-operation: FSM → IDLE, FIFO flushed, counters cleared, priority reset to 0. In-flight controller reads are not tracked afterward (they may set `rd_orphan`).

## Timing
- Reset values: all `req_*` outputs 0, all `app_*` outputs 0, `rd_orphan` 0, state IDLE.
- `req_cmd_valid` sampled in IDLE at cycle n → `app_cmd_en` at n+1 (registered state; outputs decoded from state and latch).
- Command accepted in the same cycle as `app_cmd_en & app_cmd_rdy`. Back-to-back reads cost 2 cycles per command (CMD, IDLE).
- Write data starts the cycle after command acceptance. Write-data bubbles are allowed (valid low or rdy low). `app_wdata_end` is never asserted without `app_wdata_en`.
- Read routing is combinational: zero cycles from `app_rdata_*` to `req_rdata_*`.
- Requesters hold command fields stable while `req_cmd_valid`=1 and not yet accepted.

## Structure
- Package `ddr3_app_pkg`: `APP_CMD_WR`=3'b000, `APP_CMD_RD`=3'b001, FSM state enum, default widths.
- One sub-module: `tag_fifo` (synchronous FIFO, 1-bit data, depth TAG_DEPTH, full/empty, simultaneous push/pop). All other logic stays in `ddr3_app_arbiter`.

## Test plan
- Single write from req0, burst=3, `app_cmd_rdy`=1 → `app_cmd_en` one cycle with cmd 000; 4 `app_wdata_en` beats; `app_wdata_end` on beat 4; `req_cmd_ready[0]` one pulse.
- Both request reads every cycle, burst=0 → grants alternate 0,1,0,1. Returned data flagged on `req_rdata_valid[0]`, then `[1]`, in issue order.
- req1 issues 8 reads with no return → 9th read held (`req_cmd_ready[1]`=0) while a req0 write still proceeds. One `app_rdata_end` releases the read.
- `app_cmd_rdy` low for 5 cycles in CMD → `app_cmd_en` held, address stable, no `req_cmd_ready`. Acceptance occurs on the first rdy cycle.
- Write burst=7 with `app_wdata_rdy` toggling and `req_wdata_valid` gaps → exactly 8 beats in order and end on the 8th.
- `app_rdata_valid` after reset with no reads issued → no `req_rdata_valid`, and `rd_orphan`=1 until `rst`. `rst` asserted in WDATA → all outputs 0 next cycle.
